// File: rtl/brick_field_manager.sv
// Purpose : owns the playfield bitmap (brick map plus paddle overlay) and clears bricks on ball bounces.
// Latency : data is combinational from the brick register and paddle_col; a bounce costs 1 EVAL cycle plus 1 cycle per cleared brick.
// Backpres: no handshake; a bounce that arrives while the FSM is not IDLE is dropped and sets the sticky missed flag.
//
// Ports:
//   clock, reset      rising-edge clock; asynchronous active-low reset
//   start             synchronous reload of the initial field, score and flags
//   paddle_col        leftmost paddle column (paddle sits on the last row)
//   ball_row/col/dir  ball state from the mover; a change of ball_dir is a bounce
//   data              playfield, bit r*COLS+c set when the cell holds a brick or the paddle
//   score             bricks destroyed, saturating
//   bricks_left       bricks still on the field
//   brick_hit         high for the cycle in which a brick is cleared
//   busy              FSM is not IDLE
//   level_clear       sticky, set once the last brick is gone
//   game_over         sticky, set when the ball reaches the paddle row
//   missed            sticky, set when a bounce is dropped
module brick_field_manager #(
  parameter int ROWS       = 12,
  parameter int COLS       = 16,
  parameter int BRICK_ROWS = 4,
  parameter int PADDLE_W   = 3,
  parameter int SCORE_W    = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           paddle_col,
  input  logic [3:0]           ball_row,
  input  logic [3:0]           ball_col,
  input  logic [1:0]           ball_dir,
  output logic [ROWS*COLS-1:0] data,
  output logic [SCORE_W-1:0]   score,
  output logic [7:0]           bricks_left,
  output logic                 brick_hit,
  output logic                 busy,
  output logic                 level_clear,
  output logic                 game_over,
  output logic                 missed
);

  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);

  localparam logic [N-1:0]       INIT_FIELD  = {{(N - BRICK_ROWS*COLS){1'b0}}, {(BRICK_ROWS*COLS){1'b1}}};
  localparam logic [7:0]         INIT_BRICKS = 8'(BRICK_ROWS * COLS);
  localparam logic [3:0]         LAST_ROW    = 4'(ROWS - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX   = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_CLR_V,
    S_CLR_H,
    S_CLR_D,
    S_LVL_DONE,
    S_OVER
  } state_t;

  // pend bit 0 = vertical, 1 = horizontal, 2 = diagonal neighbour
  state_t             state_q, state_d;
  logic [N-1:0]       brick_q, brick_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         bricks_left_q, bricks_left_d;
  logic               level_clear_q, level_clear_d;
  logic               game_over_q, game_over_d;
  logic               missed_q, missed_d;
  logic [1:0]         prev_dir_q, prev_dir_d;
  logic [3:0]         r_q, r_d;
  logic [3:0]         c_q, c_d;
  logic [1:0]         dir_q, dir_d;
  logic [2:0]         pend_q, pend_d;

  logic [N-1:0]       paddle_mask;
  logic               bounce;
  int                 dr, dc;
  logic               v_in, h_in, d_in;
  logic [IW-1:0]      v_idx, h_idx, d_idx;
  logic               v_occ, h_occ;
  logic               hv, hh, hd;
  logic [2:0]         clr_sel;
  logic [IW-1:0]      clr_idx;
  logic [2:0]         pend_rest;
  logic [7:0]         left_after;
  logic [SCORE_W-1:0] score_inc;

  function automatic logic cell_in(input int rr, input int cc);
    return (rr >= 0) && (rr < ROWS) && (cc >= 0) && (cc < COLS);
  endfunction

  function automatic logic [IW-1:0] cell_idx(input int rr, input int cc);
    return IW'(rr * COLS + cc);
  endfunction

  // Paddle overlay on the last row, clipped at the right wall.
  always_comb begin
    paddle_mask = '0;
    for (int i = 0; i < PADDLE_W; i++) begin
      if (int'(paddle_col) + i < COLS) begin
        paddle_mask[cell_idx(ROWS - 1, int'(paddle_col) + i)] = 1'b1;
      end
    end
  end

  assign data   = brick_q | paddle_mask;
  assign bounce = (ball_dir != prev_dir_q);

  // Neighbours of the latched ball cell along the direction it was travelling
  // before the bounce. Out-of-range cells are walls.
  always_comb begin
    dr    = dir_q[1] ? 1 : -1;
    dc    = dir_q[0] ? 1 : -1;
    v_in  = cell_in(int'(r_q) + dr, int'(c_q));
    h_in  = cell_in(int'(r_q), int'(c_q) + dc);
    d_in  = cell_in(int'(r_q) + dr, int'(c_q) + dc);
    v_idx = v_in ? cell_idx(int'(r_q) + dr, int'(c_q))      : '0;
    h_idx = h_in ? cell_idx(int'(r_q), int'(c_q) + dc)      : '0;
    d_idx = d_in ? cell_idx(int'(r_q) + dr, int'(c_q) + dc) : '0;
  end

  // Walls and paddle block the diagonal but are never bricks themselves.
  assign v_occ = !v_in || data[v_idx];
  assign h_occ = !h_in || data[h_idx];
  assign hv    = v_in && brick_q[v_idx];
  assign hh    = h_in && brick_q[h_idx];
  assign hd    = d_in && brick_q[d_idx] && !v_occ && !h_occ;

  assign score_inc = (score_q == SCORE_MAX) ? score_q : score_q + 1'b1;

  // Which neighbour the current clear state works on.
  always_comb begin
    clr_sel = 3'b000;
    clr_idx = '0;
    case (state_q)
      S_CLR_V: begin clr_sel = 3'b001; clr_idx = v_idx; end
      S_CLR_H: begin clr_sel = 3'b010; clr_idx = h_idx; end
      S_CLR_D: begin clr_sel = 3'b100; clr_idx = d_idx; end
      default: ;
    endcase
    pend_rest = pend_q & ~clr_sel;
  end

  always_comb begin
    state_d       = state_q;
    brick_d       = brick_q;
    score_d       = score_q;
    bricks_left_d = bricks_left_q;
    level_clear_d = level_clear_q;
    game_over_d   = game_over_q;
    missed_d      = missed_q;
    prev_dir_d    = ball_dir;
    r_d           = r_q;
    c_d           = c_q;
    dir_d         = dir_q;
    pend_d        = pend_q;
    brick_hit     = 1'b0;
    left_after    = bricks_left_q;

    if (start) begin
      state_d       = S_IDLE;
      brick_d       = INIT_FIELD;
      score_d       = '0;
      bricks_left_d = INIT_BRICKS;
      level_clear_d = 1'b0;
      game_over_d   = 1'b0;
      missed_d      = 1'b0;
      pend_d        = '0;
    end else begin
      if (bounce && (state_q != S_IDLE)) begin
        missed_d = 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          // Reaching the paddle row ends the game even if the ball also bounced.
          if (ball_row == LAST_ROW) begin
            state_d     = S_OVER;
            game_over_d = 1'b1;
          end else if (bounce) begin
            state_d = S_EVAL;
            r_d     = ball_row;
            c_d     = ball_col;
            dir_d   = prev_dir_q;
          end
        end
        S_EVAL: begin
          pend_d = {hd, hh, hv};
          if (hv)      state_d = S_CLR_V;
          else if (hh) state_d = S_CLR_H;
          else if (hd) state_d = S_CLR_D;
          else         state_d = S_IDLE;
        end
        S_CLR_V, S_CLR_H, S_CLR_D: begin
          // Guard keeps the count consistent with the bitmap: only a set
          // bit is ever cleared and the counter never wraps below zero.
          if (brick_q[clr_idx] && (bricks_left_q != 8'd0)) begin
            brick_d[clr_idx] = 1'b0;
            score_d          = score_inc;
            left_after       = bricks_left_q - 8'd1;
            brick_hit        = 1'b1;
          end
          bricks_left_d = left_after;
          pend_d        = pend_rest;
          if (pend_rest[1]) begin
            state_d = S_CLR_H;
          end else if (pend_rest[2]) begin
            state_d = S_CLR_D;
          end else if (left_after == 8'd0) begin
            state_d       = S_LVL_DONE;
            level_clear_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LVL_DONE: level_clear_d = 1'b1;
        S_OVER:     game_over_d   = 1'b1;
        default:    state_d       = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      brick_q       <= INIT_FIELD;
      score_q       <= '0;
      bricks_left_q <= INIT_BRICKS;
      level_clear_q <= 1'b0;
      game_over_q   <= 1'b0;
      missed_q      <= 1'b0;
      prev_dir_q    <= 2'b00;
      r_q           <= '0;
      c_q           <= '0;
      dir_q         <= 2'b00;
      pend_q        <= '0;
    end else begin
      state_q       <= state_d;
      brick_q       <= brick_d;
      score_q       <= score_d;
      bricks_left_q <= bricks_left_d;
      level_clear_q <= level_clear_d;
      game_over_q   <= game_over_d;
      missed_q      <= missed_d;
      prev_dir_q    <= prev_dir_d;
      r_q           <= r_d;
      c_q           <= c_d;
      dir_q         <= dir_d;
      pend_q        <= pend_d;
    end
  end

  assign score       = score_q;
  assign bricks_left = bricks_left_q;
  assign busy        = (state_q != S_IDLE);
  assign level_clear = level_clear_q;
  assign game_over   = game_over_q;
  assign missed      = missed_q;

endmodule
